// File: rtl/arm_mc_controller_if.sv
// Control/datapath bundle between the multicycle controller and the ARM-subset datapath.
// The controller side uses the master modport; the datapath side uses slave.
interface arm_mc_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUControl;
  logic        ShiftSel;
  logic [3:0]  State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegSrc, ALUControl, ShiftSel, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegSrc, ALUControl, ShiftSel, State
  );
endinterface

// File: rtl/arm_mc_controller.sv
// Multicycle control unit for the ARM-subset core: one shared ALU and one unified
// memory sequenced through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
// MEM_WAIT adds wait cycles to every memory access (FETCH, MEMRD, MEMWR).
// Optional feature macro: ARMMC_LSL_EN (register-form cmd 1101 as a shifter write).
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 on final wait cycle
// DECODE   | read registers, form PC+8
// MEMADR   | compute load/store address
// MEMRD    | load data read, held for wait cycles
// MEMWB    | load data write-back
// MEMWR    | store, MemWrite on final wait cycle
// EXECUTER | ALU op with register operand, flag update
// EXECUTEI | ALU op with immediate operand, flag update
// ALUWB    | ALU result write-back
// BRANCH   | PC <- PC+8+offset when condition holds
module arm_mc_controller #(
  parameter int MEM_WAIT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  arm_mc_controller_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] WAIT_N = 4'(MEM_WAIT);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] flags;
  logic       cond_ex_r;

  logic [1:0] op;
  logic [3:0] cond, cmd, rd;
  logic       s_bit, i_bit, l_bit;
  logic       wait_done;

  logic [1:0] alu_ctl;
  logic       no_write, impl, cv_wr, lsl;
  logic       cond_ex;

  logic       adr_src, alu_src_a, shift_sel;
  logic [1:0] alu_src_b, result_src, alu_control;
  logic       pc_write, ir_write, reg_write, mem_write;
  logic       unused_bits;

  assign op        = bus.Instr[27:26];
  assign cond      = bus.Instr[31:28];
  assign cmd       = bus.Instr[24:21];
  assign rd        = bus.Instr[15:12];
  assign i_bit     = bus.Instr[25];
  assign s_bit     = bus.Instr[20];
  assign l_bit     = bus.Instr[20];
  assign wait_done = (cnt == WAIT_N);
  // Rn, the shift amount and the offset are consumed by the datapath, not here.
  assign unused_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  // ALU command decode: control, write suppression and which flags get written
  always_comb begin
    alu_ctl  = 2'b00;
    no_write = 1'b1;
    impl     = 1'b0;
    cv_wr    = 1'b0;
    lsl      = 1'b0;
    case (cmd)
      4'b0100: begin alu_ctl = 2'b00; no_write = 1'b0; impl = 1'b1; cv_wr = 1'b1; end
      4'b0010: begin alu_ctl = 2'b01; no_write = 1'b0; impl = 1'b1; cv_wr = 1'b1; end
      4'b0000: begin alu_ctl = 2'b10; no_write = 1'b0; impl = 1'b1; end
      4'b1100: begin alu_ctl = 2'b11; no_write = 1'b0; impl = 1'b1; end
      4'b1010: begin alu_ctl = 2'b01; impl = 1'b1; cv_wr = 1'b1; end
      4'b1000: begin alu_ctl = 2'b10; impl = 1'b1; end
`ifdef ARMMC_LSL_EN
      4'b1101: begin
        if (!i_bit) begin
          alu_ctl  = 2'b00;
          no_write = 1'b0;
          impl     = 1'b1;
          lsl      = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Standard ARM condition evaluation against the stored {N,Z,C,V}
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // State sequencing, wait counter, flag register and latched condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      cnt       <= '0;
      flags     <= '0;
      cond_ex_r <= 1'b0;
    end else begin
      cnt <= '0;
      case (state)
        FETCH: begin
          if (wait_done) state <= DECODE;
          else           cnt   <= cnt + 4'd1;
        end
        DECODE: begin
          case (op)
            2'b01:   state <= MEMADR;
            2'b00:   state <= i_bit ? EXECUTEI : EXECUTER;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR: begin
          cond_ex_r <= cond_ex;
          state     <= l_bit ? MEMRD : MEMWR;
        end
        MEMRD: begin
          if (wait_done) state <= MEMWB;
          else           cnt   <= cnt + 4'd1;
        end
        MEMWR: begin
          if (wait_done) state <= FETCH;
          else           cnt   <= cnt + 4'd1;
        end
        EXECUTER, EXECUTEI: begin
          cond_ex_r <= cond_ex;
          if (s_bit && cond_ex && impl) begin
            flags[3:2] <= bus.ALUFlags[3:2];
            if (cv_wr) flags[1:0] <= bus.ALUFlags[1:0];
          end
          state <= ALUWB;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Per-state control outputs; write enables are killed while reset is high
  always_comb begin
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    shift_sel   = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    case (state)
      FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = wait_done;
        pc_write   = wait_done;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: alu_src_b = 2'b01;
      MEMRD:  adr_src   = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_ex_r & (rd != 4'd15);
        pc_write   = cond_ex_r & (rd == 4'd15);
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = wait_done & cond_ex_r;
      end
      EXECUTER: begin
        alu_control = alu_ctl;
        shift_sel   = lsl;
      end
      EXECUTEI: begin
        alu_src_b   = 2'b01;
        alu_control = alu_ctl;
      end
      ALUWB: begin
        shift_sel = lsl;
        reg_write = cond_ex_r & ~no_write & (rd != 4'd15);
        pc_write  = cond_ex_r & ~no_write & (rd == 4'd15);
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_control;
  assign bus.ShiftSel   = shift_sel;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.State      = state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: three instances with MEM_WAIT = 0, 1, 2
// share clock and reset; each scenario task checks its own expected values.
module tb_arm_mc_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  arm_mc_controller_if b0();
  arm_mc_controller_if b1();
  arm_mc_controller_if b2();

  arm_mc_controller #(.MEM_WAIT(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  arm_mc_controller #(.MEM_WAIT(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  arm_mc_controller #(.MEM_WAIT(2)) u2 (.clk(clk), .reset(reset), .bus(b2));

  always #5 clk = ~clk;

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) next_cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    b0.Instr = 32'hE2812005; b0.ALUFlags = 4'h0;
    b1.Instr = 32'hE2812005; b1.ALUFlags = 4'h0;
    b2.Instr = 32'hE2812005; b2.ALUFlags = 4'h0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (b0.State !== 4'd0) $display("FAIL reset_state: got %0d want 0", b0.State);
    else n_pass++;
    n_total++;
    if ({b0.PCWrite, b0.IRWrite, b0.RegWrite, b0.MemWrite} !== 4'b0000)
      $display("FAIL reset_enables: got %b want 0000",
               {b0.PCWrite, b0.IRWrite, b0.RegWrite, b0.MemWrite});
    else n_pass++;
    n_total++;
    if ({b0.AdrSrc, b0.ALUSrcA, b0.ALUSrcB, b0.ResultSrc, b0.ALUControl} !== 8'b0_1_10_10_00)
      $display("FAIL reset_muxes: got %b want 01101000",
               {b0.AdrSrc, b0.ALUSrcA, b0.ALUSrcB, b0.ResultSrc, b0.ALUControl});
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if ({b0.PCWrite, b0.IRWrite} !== 2'b11)
      $display("FAIL fetch_w0_final: got %b want 11", {b0.PCWrite, b0.IRWrite});
    else n_pass++;
    n_total++;
    if ({b2.PCWrite, b2.IRWrite} !== 2'b00)
      $display("FAIL fetch_w2_first: got %b want 00", {b2.PCWrite, b2.IRWrite});
    else n_pass++;
  endtask

  task automatic test_add();
    logic [3:0] es [0:4];
    es = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    b0.Instr = 32'hE2812005;
    b0.ALUFlags = 4'h0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (b0.State !== es[k]) $display("FAIL add_state k=%0d: got %0d want %0d", k, b0.State, es[k]);
      else n_pass++;
      n_total++;
      if (b0.RegWrite !== (k == 3)) $display("FAIL add_regwrite k=%0d: got %b want %b", k, b0.RegWrite, (k == 3));
      else n_pass++;
      if (k == 2) begin
        n_total++;
        if (b0.ALUSrcB !== 2'b01) $display("FAIL add_alusrcb: got %b want 01", b0.ALUSrcB);
        else n_pass++;
        n_total++;
        if (b0.ImmSrc !== 2'b00) $display("FAIL add_immsrc: got %b want 00", b0.ImmSrc);
        else n_pass++;
      end
      if (k < 4) next_cyc();
    end
  endtask

  task automatic test_ldr();
    logic [3:0] es [0:9];
    es = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    b2.Instr = 32'hE5903008;
    b2.ALUFlags = 4'h0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      n_total++;
      if (b2.State !== es[k]) $display("FAIL ldr_state k=%0d: got %0d want %0d", k, b2.State, es[k]);
      else n_pass++;
      n_total++;
      if (b2.IRWrite !== (k == 2)) $display("FAIL ldr_irwrite k=%0d: got %b want %b", k, b2.IRWrite, (k == 2));
      else n_pass++;
      n_total++;
      if (b2.RegWrite !== (k == 8)) $display("FAIL ldr_regwrite k=%0d: got %b want %b", k, b2.RegWrite, (k == 8));
      else n_pass++;
      n_total++;
      if (b2.AdrSrc !== (k >= 5 && k <= 7)) $display("FAIL ldr_adrsrc k=%0d: got %b want %b", k, b2.AdrSrc, (k >= 5 && k <= 7));
      else n_pass++;
      if (k == 8) begin
        n_total++;
        if (b2.ResultSrc !== 2'b01) $display("FAIL ldr_resultsrc: got %b want 01", b2.ResultSrc);
        else n_pass++;
      end
      if (k < 9) next_cyc();
    end
  endtask

  task automatic test_cond();
    // CMP sets Z, then ADDEQ writes
    b0.Instr = 32'hE3510005; b0.ALUFlags = 4'b0100;
    do_reset();
    run(3);
    n_total++;
    if ({b0.State, b0.RegWrite} !== {4'd8, 1'b0}) $display("FAIL cmp_nowrite: got %0d/%b want 8/0", b0.State, b0.RegWrite);
    else n_pass++;
    run(1);
    b0.Instr = 32'h02812001; b0.ALUFlags = 4'h0;
    run(3);
    n_total++;
    if ({b0.State, b0.RegWrite} !== {4'd8, 1'b1}) $display("FAIL addeq_z1: got %0d/%b want 8/1", b0.State, b0.RegWrite);
    else n_pass++;
    // flags 0000 after reset: ADDEQ suppressed
    b0.Instr = 32'h02812001;
    do_reset();
    run(3);
    n_total++;
    if ({b0.State, b0.RegWrite} !== {4'd8, 1'b0}) $display("FAIL addeq_z0: got %0d/%b want 8/0", b0.State, b0.RegWrite);
    else n_pass++;
    // CMP writes C: ADDCS executes
    b0.Instr = 32'hE3510005; b0.ALUFlags = 4'b0010;
    do_reset();
    run(4);
    b0.Instr = 32'h22812001; b0.ALUFlags = 4'h0;
    run(3);
    n_total++;
    if (b0.RegWrite !== 1'b1) $display("FAIL addcs_after_cmp: got %b want 1", b0.RegWrite);
    else n_pass++;
    // TST leaves C alone: ADDCS suppressed
    b0.Instr = 32'hE3110001; b0.ALUFlags = 4'b0010;
    do_reset();
    run(4);
    b0.Instr = 32'h22812001; b0.ALUFlags = 4'h0;
    run(3);
    n_total++;
    if (b0.RegWrite !== 1'b0) $display("FAIL addcs_after_tst: got %b want 0", b0.RegWrite);
    else n_pass++;
  endtask

  task automatic test_branch();
    b0.Instr = 32'hEAFFFFFE; b0.ALUFlags = 4'h0;
    do_reset();
    next_cyc();
    n_total++;
    if (b0.State !== 4'd1) $display("FAIL b_decode: got %0d want 1", b0.State);
    else n_pass++;
    next_cyc();
    n_total++;
    if ({b0.State, b0.PCWrite, b0.ALUSrcA, b0.ALUSrcB} !== {4'd9, 1'b1, 1'b0, 2'b01})
      $display("FAIL b_branch: got %0d/%b/%b/%b want 9/1/0/01", b0.State, b0.PCWrite, b0.ALUSrcA, b0.ALUSrcB);
    else n_pass++;
    next_cyc();
    n_total++;
    if (b0.State !== 4'd0) $display("FAIL b_return: got %0d want 0", b0.State);
    else n_pass++;
    // BNE with Z = 1 after CMP
    b0.Instr = 32'hE3510005; b0.ALUFlags = 4'b0100;
    do_reset();
    run(4);
    b0.Instr = 32'h1AFFFFFE; b0.ALUFlags = 4'h0;
    run(2);
    n_total++;
    if ({b0.State, b0.PCWrite} !== {4'd9, 1'b0}) $display("FAIL bne_z1: got %0d/%b want 9/0", b0.State, b0.PCWrite);
    else n_pass++;
    // BNE with Z = 0
    b0.Instr = 32'h1AFFFFFE;
    do_reset();
    run(2);
    n_total++;
    if ({b0.State, b0.PCWrite} !== {4'd9, 1'b1}) $display("FAIL bne_z0: got %0d/%b want 9/1", b0.State, b0.PCWrite);
    else n_pass++;
  endtask

  task automatic test_str();
    logic [3:0] es [0:6];
    int mem_high;
    es = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    mem_high = 0;
    b1.Instr = 32'hE5803004; b1.ALUFlags = 4'h0;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (b1.MemWrite === 1'b1) mem_high++;
      n_total++;
      if (b1.State !== es[k]) $display("FAIL str_state k=%0d: got %0d want %0d", k, b1.State, es[k]);
      else n_pass++;
      n_total++;
      if (b1.MemWrite !== (k == 5)) $display("FAIL str_memwrite k=%0d: got %b want %b", k, b1.MemWrite, (k == 5));
      else n_pass++;
      n_total++;
      if (b1.AdrSrc !== (k == 4 || k == 5)) $display("FAIL str_adrsrc k=%0d: got %b want %b", k, b1.AdrSrc, (k == 4 || k == 5));
      else n_pass++;
      if (k < 6) next_cyc();
    end
    n_total++;
    if (mem_high !== 1) $display("FAIL str_memwrite_count: got %0d want 1", mem_high);
    else n_pass++;
    // asynchronous abort in MEMADR
    do_reset();
    run(3);
    n_total++;
    if (b1.State !== 4'd2) $display("FAIL str_memadr: got %0d want 2", b1.State);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({b1.State, b1.PCWrite, b1.IRWrite, b1.RegWrite, b1.MemWrite} !== 8'h00)
      $display("FAIL str_async_abort: got %0d/%b want 0/0000", b1.State,
               {b1.PCWrite, b1.IRWrite, b1.RegWrite, b1.MemWrite});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if ({b1.State, b1.PCWrite, b1.IRWrite, b1.RegWrite, b1.MemWrite} !== 8'h00)
      $display("FAIL str_after_release: got %0d/%b want 0/0000", b1.State,
               {b1.PCWrite, b1.IRWrite, b1.RegWrite, b1.MemWrite});
    else n_pass++;
    next_cyc();
    n_total++;
    if (b1.IRWrite !== 1'b1) $display("FAIL str_refetch: got %b want 1", b1.IRWrite);
    else n_pass++;
  endtask

  task automatic test_lsl();
    logic exp_lsl;
`ifdef ARMMC_LSL_EN
    exp_lsl = 1'b1;
`else
    exp_lsl = 1'b0;
`endif
    b0.Instr = 32'hE1A02101; b0.ALUFlags = 4'h0;
    do_reset();
    run(2);
    n_total++;
    if ({b0.State, b0.ShiftSel} !== {4'd6, exp_lsl}) $display("FAIL lsl_executer: got %0d/%b want 6/%b", b0.State, b0.ShiftSel, exp_lsl);
    else n_pass++;
    next_cyc();
    n_total++;
    if ({b0.State, b0.ShiftSel, b0.RegWrite} !== {4'd8, exp_lsl, exp_lsl})
      $display("FAIL lsl_aluwb: got %0d/%b/%b want 8/%b/%b", b0.State, b0.ShiftSel, b0.RegWrite, exp_lsl, exp_lsl);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_cond();
    test_branch();
    test_str();
    test_lsl();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
